lcd_cmd_issuer: RTL and testbench
=================================

// Module: lcd_cmd_issuer
// PURPOSE
//  Upstream command stage for the LCD image-display controller. Accepts 4-bit display commands from a host
//  over a valid/ready handshake, buffers them in a small FIFO, and drives cmd/cmd_valid into the controller.
//  Obeys the controller's busy/done protocol: never issues while busy, and holds after Write until done.
//  Filters illegal opcodes (12..15) before they reach the controller.
// PARAMETERS
//  DEPTH     8   FIFO entries; power of two, >= 2
//  HOLD_CYC  1   cycles after a cmd_valid pulse before lcd_busy is sampled again; 1..7
// PORTS
//  clk          in   1            single clock, rising edge
//  reset        in   1            asynchronous, active-high; clears all state
//  host_cmd     in   4            command opcode from host
//  host_valid   in   1            host_cmd valid
//  host_ready   out  1            issuer accepts host_cmd this cycle
//  lcd_busy     in   1            controller busy
//  lcd_done     in   1            controller finished output of frame (1-cycle pulse)
//  cmd          out  4            opcode to controller
//  cmd_valid    out  1            1-cycle strobe qualifying cmd
//  fifo_level   out  $clog2(DEPTH)+1  entries currently queued
//  frame_done   out  1            1-cycle pulse, registered copy of lcd_done seen in WAIT_DONE
//  err_illegal  out  1            1-cycle pulse: illegal opcode was accepted and dropped
// BEHAVIOUR
//  - Reset (async, active-high): host_ready=0 during reset, cmd=0, cmd_valid=0, fifo_level=0, frame_done=0,
//    err_illegal=0, FSM=IDLE, FIFO pointers 0. Reset mid-issue drops cmd_valid immediately; queue discarded.
//  - host_ready = !full (registered level). Transfer when host_valid & host_ready.
//  - Opcodes 0..11 enqueue; 12..15 consumed but not enqueued, err_illegal=1 next cycle.
//  - Simultaneous push and pop: both occur, level unchanged. Full: no push. Empty: no pop.
//  - Pointers wrap modulo DEPTH; level is separate counter, 0..DEPTH.
//  - FSM:
//    IDLE      : if !fifo_empty & !lcd_busy -> ISSUE (pop head into cmd register).
//    ISSUE     : cmd_valid=1 for exactly this cycle; cmd holds opcode.
//                opcode==0 (Write) -> WAIT_DONE; else -> HOLD, cnt=HOLD_CYC.
//    HOLD      : count down; at 0 -> WAIT_BUSY.
//    WAIT_BUSY : stay while lcd_busy; lcd_busy==0 -> IDLE.
//    WAIT_DONE : stay until lcd_done; then frame_done=1 next cycle -> IDLE.
//  - Latency: head available & busy low -> cmd_valid 1 cycle later (IDLE->ISSUE register stage).
//  - Minimum issue spacing: 2+HOLD_CYC cycles. cmd retains last opcode while cmd_valid=0.
//  - lcd_done outside WAIT_DONE is ignored. lcd_busy high in IDLE simply stalls.
//  - FIFO accepts host commands in every state, including WAIT_DONE (next-frame commands queue up).
// CONFIGURATION
//  LCD_CMD_STATS_EN defined: adds outputs issued_cnt[15:0] (incremented per cmd_valid, saturates 16'hFFFF)
//    and dropped_cnt[7:0] (per err_illegal, saturates 8'hFF); both reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package lcd_pkg: opcode localparams (CMD_WRITE=0 .. CMD_MIRROR_Y=11), CMD_W=4,
//    issuer state enum {IDLE, ISSUE, HOLD, WAIT_BUSY, WAIT_DONE}, function is_legal_cmd().
//  Sub-module lcd_cmd_fifo: DEPTH x 4 synchronous FIFO with push/pop/full/empty/level; FSM in top.
// TESTING
//  1. Reset with host_valid=1: host_ready=0, cmd_valid=0; after release, level=0, host_ready=1.
//  2. Push 3,1,5 with lcd_busy=0: cmd_valid pulses carry 3,1,5 in order, spacing exactly 3 cycles (HOLD_CYC=1).
//  3. Push 4 with lcd_busy=1 for 10 cycles: no cmd_valid until busy falls, then cmd=4 one cycle later.
//  4. Push 8 commands while busy=1: level=8, host_ready=0, 9th held; pop+push same cycle keeps level=8.
//  5. Push 14: err_illegal pulses once, level unchanged, no cmd_valid; (STATS_EN) dropped_cnt=1.
//  6. Push 0 then 2: after Write, cmd 2 withheld until lcd_done; frame_done pulses, then cmd=2 issued.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared opcode, state and helper definitions for the LCD command path.
package lcd_pkg;

    localparam int CMD_W = 4;

    localparam logic [CMD_W-1:0] CMD_WRITE     = 4'd0;
    localparam logic [CMD_W-1:0] CMD_BRIGHT_UP = 4'd1;
    localparam logic [CMD_W-1:0] CMD_BRIGHT_DN = 4'd2;
    localparam logic [CMD_W-1:0] CMD_INVERT    = 4'd3;
    localparam logic [CMD_W-1:0] CMD_THRESHOLD = 4'd4;
    localparam logic [CMD_W-1:0] CMD_ROT_L     = 4'd5;
    localparam logic [CMD_W-1:0] CMD_ROT_R     = 4'd6;
    localparam logic [CMD_W-1:0] CMD_ZOOM_IN   = 4'd7;
    localparam logic [CMD_W-1:0] CMD_ZOOM_OUT  = 4'd8;
    localparam logic [CMD_W-1:0] CMD_SHIFT     = 4'd9;
    localparam logic [CMD_W-1:0] CMD_MIRROR_X  = 4'd10;
    localparam logic [CMD_W-1:0] CMD_MIRROR_Y  = 4'd11;

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT_BUSY, WAIT_DONE} issuer_state_e;

    function automatic logic is_legal_cmd(input logic [CMD_W-1:0] op);
        return op <= CMD_MIRROR_Y;
    endfunction

endpackage

// File: rtl/lcd_cmd_issuer_if.sv
// Host handshake and controller command bus for lcd_cmd_issuer.
interface lcd_cmd_issuer_if;
    import lcd_pkg::*;

    logic [CMD_W-1:0] host_cmd;
    logic             host_valid;
    logic             host_ready;
    logic             lcd_busy;
    logic             lcd_done;
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;

    modport master (output host_cmd, host_valid, lcd_busy, lcd_done,
                    input  host_ready, cmd, cmd_valid);
    modport slave  (input  host_cmd, host_valid, lcd_busy, lcd_done,
                    output host_ready, cmd, cmd_valid);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// DEPTH x CMD_W synchronous FIFO; head is read combinationally, pop advances it.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [CMD_W-1:0]       din,
    output logic [CMD_W-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level_q;
    logic             push_ok, pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/lcd_cmd_issuer.sv
// Queues host opcodes and issues them to the LCD controller under its busy/done protocol.
// Optional LCD_CMD_STATS_EN adds issued_cnt / dropped_cnt saturating counters.
module lcd_cmd_issuer
    import lcd_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    lcd_cmd_issuer_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   frame_done,
`ifdef LCD_CMD_STATS_EN
    output logic [15:0]            issued_cnt,
    output logic [7:0]             dropped_cnt,
`endif
    output logic                   err_illegal
);
    issuer_state_e    state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CMD_W-1:0] cmd_q, head;
    logic             fifo_full, fifo_empty;
    logic             accept, push, pop, illegal;

    assign bus.host_ready = ~fifo_full & ~reset;
    assign accept         = bus.host_valid & bus.host_ready;
    assign push           = accept & is_legal_cmd(bus.host_cmd);
    assign illegal        = accept & ~is_legal_cmd(bus.host_cmd);
    assign bus.cmd        = cmd_q;
    assign bus.cmd_valid  = (state_q == ISSUE);

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.host_cmd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty && !bus.lcd_busy) begin
                pop     = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (cmd_q == CMD_WRITE) state_d = WAIT_DONE;
                   else begin
                       state_d = HOLD;
                       cnt_d   = 3'(HOLD_CYC);
                   end
            HOLD: if (cnt_q <= 3'd1) state_d = WAIT_BUSY;
                  else cnt_d = cnt_q - 3'd1;
            // Issuing straight from here keeps back-to-back spacing at 2+HOLD_CYC.
            WAIT_BUSY: if (!bus.lcd_busy) begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: if (bus.lcd_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            frame_done  <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (pop) cmd_q <= head;
            frame_done  <= (state_q == WAIT_DONE) & bus.lcd_done;
            err_illegal <= illegal;
        end
    end

`ifdef LCD_CMD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_cnt  <= '0;
            dropped_cnt <= '0;
        end else begin
            if (state_q == ISSUE && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
            if (illegal && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed bench for lcd_cmd_issuer: per-cycle vector table plus hand-written corner sequences.
module tb_lcd_cmd_issuer;
    import lcd_pkg::*;

    localparam int DEPTH    = 8;
    localparam int HOLD_CYC = 1;
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int NVEC     = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [LW-1:0] fifo_level;
    logic          frame_done, err_illegal;
`ifdef LCD_CMD_STATS_EN
    logic [15:0]   issued_cnt;
    logic [7:0]    dropped_cnt;
`endif

    lcd_cmd_issuer_if bus();

    lcd_cmd_issuer #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .fifo_level  (fifo_level),
        .frame_done  (frame_done),
`ifdef LCD_CMD_STATS_EN
        .issued_cnt  (issued_cnt),
        .dropped_cnt (dropped_cnt),
`endif
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    hc;
        logic          hv, busy, done;
        logic          cv;
        logic [3:0]    cmd;
        logic [LW-1:0] lvl;
        logic          rdy, fd, err;
    } vec_t;

    vec_t tbl [NVEC];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int hc, int hv, int bz, int dn, int cv, int cm, int lv, int fd, int er);
        vec_t r;
        r.hc = 4'(hc); r.hv = 1'(hv); r.busy = 1'(bz); r.done = 1'(dn);
        r.cv = 1'(cv); r.cmd = 4'(cm); r.lvl = LW'(lv); r.rdy = 1'b1;
        r.fd = 1'(fd); r.err = 1'(er);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] hc, input logic hv, input logic bz, input logic dn);
        bus.host_cmd   = hc;
        bus.host_valid = hv;
        bus.lcd_busy   = bz;
        bus.lcd_done   = dn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  exp_next;
        logic seen;

        // hc hv busy done | cv cmd lvl fd err   (outputs sampled after the edge)
        tbl[0]  = mk( 3,1,0,0, 0, 0,1,0,0);
        tbl[1]  = mk( 1,1,0,0, 1, 3,1,0,0);
        tbl[2]  = mk( 5,1,0,0, 0, 3,2,0,0);
        tbl[3]  = mk( 0,0,0,0, 0, 3,2,0,0);
        tbl[4]  = mk( 0,0,0,0, 1, 1,1,0,0);
        tbl[5]  = mk( 0,0,0,0, 0, 1,1,0,0);
        tbl[6]  = mk( 0,0,0,0, 0, 1,1,0,0);
        tbl[7]  = mk( 0,0,0,0, 1, 5,0,0,0);
        tbl[8]  = mk( 0,0,0,0, 0, 5,0,0,0);
        tbl[9]  = mk( 0,0,0,0, 0, 5,0,0,0);
        tbl[10] = mk( 0,0,0,0, 0, 5,0,0,0);
        tbl[11] = mk(14,1,0,0, 0, 5,0,0,1);
        tbl[12] = mk( 0,0,0,0, 0, 5,0,0,0);
        tbl[13] = mk( 0,1,0,0, 0, 5,1,0,0);
        tbl[14] = mk( 2,1,0,0, 1, 0,1,0,0);
        tbl[15] = mk( 0,0,0,0, 0, 0,1,0,0);
        tbl[16] = mk( 0,0,0,0, 0, 0,1,0,0);
        tbl[17] = mk( 0,0,0,0, 0, 0,1,0,0);
        tbl[18] = mk( 0,0,0,1, 0, 0,1,1,0);
        tbl[19] = mk( 0,0,0,0, 1, 2,0,0,0);
        tbl[20] = mk( 0,0,0,0, 0, 2,0,0,0);
        tbl[21] = mk( 0,0,0,0, 0, 2,0,0,0);
        tbl[22] = mk( 0,0,0,1, 0, 2,0,0,0);
        tbl[23] = mk( 0,0,0,0, 0, 2,0,0,0);
        tbl[24] = mk(12,1,0,0, 0, 2,0,0,1);
        tbl[25] = mk(11,1,0,0, 0, 2,1,0,0);
        tbl[26] = mk( 0,0,0,0, 1,11,0,0,0);
        tbl[27] = mk( 0,0,0,0, 0,11,0,0,0);
        tbl[28] = mk( 0,0,0,0, 0,11,0,0,0);
        tbl[29] = mk( 0,0,0,0, 0,11,0,0,0);

        // Reset held with a valid host request: nothing may be accepted or issued.
        set_in(4'd3, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) tick;
        chk("rst host_ready", 32'(bus.host_ready), 32'd0);
        chk("rst cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst state", 32'({bus.cmd, fifo_level, frame_done, err_illegal}), 32'd0);
        bus.host_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post-rst host_ready", 32'(bus.host_ready), 32'd1);
        tick;
        chk("post-rst level", 32'(fifo_level), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            set_in(tbl[i].hc, tbl[i].hv, tbl[i].busy, tbl[i].done);
            tick;
            chk($sformatf("vec%0d {cv,cmd,lvl,rdy,fd,err}", i),
                32'({bus.cmd_valid, bus.cmd, fifo_level, bus.host_ready, frame_done, err_illegal}),
                32'({tbl[i].cv, tbl[i].cmd, tbl[i].lvl, tbl[i].rdy, tbl[i].fd, tbl[i].err}));
        end

        // Busy stall: queued command waits until busy falls, then issues one cycle later.
        set_in(4'd4, 1'b1, 1'b1, 1'b0);
        tick;
        bus.host_valid = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick;
            if (bus.cmd_valid) seen = 1'b1;
        end
        chk("busy stall no cmd_valid", 32'(seen), 32'd0);
        chk("busy stall level", 32'(fifo_level), 32'd1);
        bus.lcd_busy = 1'b0;
        tick;
        chk("busy release issue", 32'({bus.cmd_valid, bus.cmd}), 32'({1'b1, 4'd4}));
        repeat (4) tick;

        // Fill to full while busy; the ninth command must wait for space.
        bus.lcd_busy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.host_cmd   = 4'(k);
            bus.host_valid = 1'b1;
            tick;
        end
        chk("full level", 32'(fifo_level), 32'd8);
        chk("full host_ready", 32'(bus.host_ready), 32'd0);
        bus.host_cmd = 4'd9;
        repeat (3) tick;
        chk("full ninth held", 32'(fifo_level), 32'd8);
        bus.lcd_busy = 1'b0;
        tick;
        chk("full first pop", 32'({bus.cmd_valid, bus.cmd, fifo_level}), 32'({1'b1, 4'd1, 4'd7}));
        tick;
        chk("full ninth accepted", 32'(fifo_level), 32'd8);
        bus.host_valid = 1'b0;
        exp_next = 2;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (bus.cmd_valid) begin
                chk("drain order", 32'(bus.cmd), 32'(exp_next));
                exp_next++;
            end
        end
        chk("drain count", 32'(exp_next), 32'd10);
        chk("drain level", 32'(fifo_level), 32'd0);

        // Push and pop in the same cycle leave the level unchanged.
        set_in(4'd5, 1'b1, 1'b1, 1'b0);
        tick;
        set_in(4'd6, 1'b1, 1'b0, 1'b0);
        tick;
        chk("push+pop", 32'({bus.cmd_valid, bus.cmd, fifo_level}), 32'({1'b1, 4'd5, 4'd1}));
        bus.host_valid = 1'b0;
        repeat (6) tick;
        chk("push+pop drained", 32'(fifo_level), 32'd0);

`ifdef LCD_CMD_STATS_EN
        chk("issued_cnt", 32'(issued_cnt), 32'd18);
        chk("dropped_cnt", 32'(dropped_cnt), 32'd2);
`endif

        // Reset arriving mid-issue drops cmd_valid at once and discards the queue.
        set_in(4'd7, 1'b1, 1'b0, 1'b0);
        tick;
        bus.host_cmd = 4'd8;
        tick;
        bus.host_valid = 1'b0;
        chk("pre-rst issue", 32'({bus.cmd_valid, bus.cmd, fifo_level}), 32'({1'b1, 4'd7, 4'd1}));
        #2 reset = 1'b1;
        #1;
        chk("mid-rst cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("mid-rst level/ready", 32'({fifo_level, bus.host_ready}), 32'd0);
`ifdef LCD_CMD_STATS_EN
        chk("mid-rst counters", 32'({issued_cnt, dropped_cnt}), 32'd0);
`endif
        #2 reset = 1'b0;
        tick;
        chk("after mid-rst", 32'({bus.cmd_valid, bus.cmd, fifo_level, bus.host_ready}), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
